symbol_packer: RTL and testbench

SYMBOL_PACKER -- requirements
Module: symbol_packer

---
 rtl/symbol_packer.sv | 168 ++++++++++++++++
 tb/tb_symbol_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_packer.sv
// Packs BPSK/QPSK symbols MSB-first into bytes behind a first-word-fall-through FIFO.
// Define SYMBOL_PACKER_STATS_EN to add the frame_cnt / drop_cnt outputs.
module symbol_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [3:0]  m_tbits,
  output logic        overflow
`ifdef SYMBOL_PACKER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [7:0]    acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [7:0] mem_data [FIFO_DEPTH];
  logic [3:0] mem_bits [FIFO_DEPTH];
  logic       mem_last [FIFO_DEPTH];

  logic [7:0] a, nacc;
  logic [3:0] ncnt, tot;
  logic [2:0] idx;
  logic [1:0] need, push_n;
  logic [7:0] e0_data, e1_data;
  logic [3:0] e0_bits, e1_bits;
  logic       e0_last, e1_last;
  logic       pop, drop, accept;
  logic [CW:0] space;

  // Work out what this beat would do if accepted; drop is decided after.
  always_comb begin
    a       = acc_q;
    nacc    = acc_q;
    ncnt    = cnt_q;
    tot     = '0;
    idx     = ~cnt_q[2:0];
    need    = 2'd0;
    e0_data = '0;
    e0_bits = '0;
    e0_last = 1'b0;
    e1_data = '0;
    e1_bits = '0;
    e1_last = 1'b0;
    if (!s_tuser && cnt_q == 4'd7) begin
      a[0]    = s_tdata[1];
      e0_data = a;
      e0_bits = 4'd8;
      if (s_tlast) begin
        need    = 2'd2;
        e1_data = {s_tdata[0], 7'b0};
        e1_bits = 4'd1;
        e1_last = 1'b1;
        nacc    = '0;
        ncnt    = '0;
      end else begin
        need = 2'd1;
        nacc = {s_tdata[0], 7'b0};
        ncnt = 4'd1;
      end
    end else begin
      a[idx] = s_tdata[1];
      if (!s_tuser) a[idx - 3'd1] = s_tdata[0];
      tot = cnt_q + (s_tuser ? 4'd1 : 4'd2);
      if (tot == 4'd8 || s_tlast) begin
        need    = 2'd1;
        e0_data = a;
        e0_bits = tot;
        e0_last = s_tlast;
        nacc    = '0;
        ncnt    = '0;
      end else begin
        nacc = a;
        ncnt = tot;
      end
    end
  end

  assign pop    = m_tvalid & m_tready;
  assign space  = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, pop};
  assign drop   = s_tvalid & ({{(CW-1){1'b0}}, need} > space);
  assign accept = s_tvalid & ~drop;
  assign push_n = accept ? need : 2'd0;

  assign acc_d   = accept ? nacc : acc_q;
  assign cnt_d   = accept ? ncnt : cnt_q;
  assign wr_d    = wr_q + AW'(push_n);
  assign rd_d    = rd_q + AW'(pop);
  assign count_d = count_q + CW'(push_n) - CW'(pop);
  assign ovf_d   = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_data[wr_q] <= e0_data;
      mem_bits[wr_q] <= e0_bits;
      mem_last[wr_q] <= e0_last;
    end
    if (push_n == 2'd2) begin
      mem_data[wr_q + AW'(1)] <= e1_data;
      mem_bits[wr_q + AW'(1)] <= e1_bits;
      mem_last[wr_q + AW'(1)] <= e1_last;
    end
  end

  // Storage is not reset, so outputs are masked while the FIFO is empty.
  assign m_tvalid = count_q != '0;
  assign s_tready = count_q != DEPTH_W[CW-1:0];
  assign m_tdata  = m_tvalid ? mem_data[rd_q] : '0;
  assign m_tbits  = m_tvalid ? mem_bits[rd_q] : '0;
  assign m_tlast  = m_tvalid ? mem_last[rd_q] : 1'b0;
  assign overflow = ovf_q;

`ifdef SYMBOL_PACKER_STATS_EN
  logic [15:0] frame_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      if (pop && m_tlast) frame_q <= frame_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_symbol_packer.sv
// Bench for symbol_packer: directed frames plus random traffic
// against a bit-queue reference model.
module tb_symbol_packer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tuser;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;
  logic [3:0] m_tbits;
  logic       overflow;
`ifdef SYMBOL_PACKER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  symbol_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_tbits  (m_tbits),
    .overflow (overflow)
`ifdef SYMBOL_PACKER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] n;
    logic       l;
  } ent_t;

  ent_t mq[$];
  ent_t dut_log[$];
  bit   pend[$];
  bit   m_ovf;
  int   m_frames;
  int   m_drops;
  int   n_chk;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t pack(input bit b[$], input bit l);
    ent_t e;
    e.d = '0;
    foreach (b[i]) e.d[7-i] = b[i];
    e.n = 4'(b.size());
    e.l = l;
    return e;
  endfunction

  task automatic model_step();
    bit   pop;
    int   free;
    bit   bits[$];
    bit   tmp[$];
    ent_t outs[$];
    pop  = m_tready && mq.size() > 0;
    free = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop && mq[0].l) m_frames++;
    if (pop) void'(mq.pop_front());
    if (s_tvalid) begin
      bits.push_back(s_tdata[1]);
      if (!s_tuser) bits.push_back(s_tdata[0]);
      tmp = pend;
      foreach (bits[i]) begin
        tmp.push_back(bits[i]);
        if (tmp.size() == 8) begin
          outs.push_back(pack(tmp, s_tlast && i == bits.size() - 1));
          tmp.delete();
        end
      end
      if (s_tlast && tmp.size() > 0) begin
        outs.push_back(pack(tmp, 1'b1));
        tmp.delete();
      end
      if (outs.size() > free) begin
        m_ovf = 1'b1;
        m_drops++;
      end else begin
        pend = tmp;
        foreach (outs[i]) mq.push_back(outs[i]);
      end
    end
  endtask

  task automatic cycle(input bit v, input bit u, input bit l,
                       input logic [1:0] d, input bit r);
    ent_t e;
    s_tvalid = v;
    s_tuser  = u;
    s_tlast  = l;
    s_tdata  = d;
    m_tready = r;
    @(negedge clk);
    chk("m_tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
    chk("s_tready", 32'(s_tready), 32'(mq.size() < DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk("m_tdata", 32'(m_tdata), 32'(mq[0].d));
      chk("m_tbits", 32'(m_tbits), 32'(mq[0].n));
      chk("m_tlast", 32'(m_tlast), 32'(mq[0].l));
    end
`ifdef SYMBOL_PACKER_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(16'(m_frames)));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops > 65535 ? 65535 : m_drops));
`endif
    if (m_tvalid && m_tready) begin
      e.d = m_tdata;
      e.n = m_tbits;
      e.l = m_tlast;
      dut_log.push_back(e);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, r);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 2'b00;
    m_tready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    pend.delete();
    dut_log.delete();
    m_ovf    = 1'b0;
    m_frames = 0;
    m_drops  = 0;
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_m_tbits", 32'(m_tbits), 0);
    chk("rst_s_tready", 32'(s_tready), 1);
    chk("rst_overflow", 32'(overflow), 0);
  endtask

  task automatic expect_log(input string tag, input int idx,
                            input logic [7:0] d, input logic [3:0] n,
                            input logic l);
    if (idx < dut_log.size()) begin
      chk({tag, "_data"}, 32'(dut_log[idx].d), 32'(d));
      chk({tag, "_bits"}, 32'(dut_log[idx].n), 32'(n));
      chk({tag, "_last"}, 32'(dut_log[idx].l), 32'(l));
    end
  endtask

  task automatic overflow_run();
    logic [7:0] ob [5];
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < 8; i++)
        cycle(1'b1, 1'b1, 1'b0, {ob[b][7-i], 1'b0}, 1'b0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_full", 32'(s_tready), 0);
    chk("ovf_held", 32'(dut_log.size()), 0);
  endtask

  initial begin
    logic [7:0] pat;
    n_chk = 0;
    n_err = 0;
    do_reset();

    pat = 8'hB2;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, i == 7, {pat[7-i], 1'b0}, 1'b1);
    chk("b2_lat_valid", 32'(m_tvalid), 1);
    chk("b2_lat_data", 32'(m_tdata), 32'hB2);
    idle(1'b1, 3);
    chk("b2_count", 32'(dut_log.size()), 1);
    expect_log("b2", 0, 8'hB2, 4'd8, 1'b1);

    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 2'b10, 1'b1);
    idle(1'b1, 3);
    chk("d2_count", 32'(dut_log.size()), 2);
    expect_log("d2_0", 0, 8'hD2, 4'd8, 1'b0);
    expect_log("d2_1", 1, 8'h80, 4'd1, 1'b1);

    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    idle(1'b1, 4);
    chk("fe_count", 32'(dut_log.size()), 2);
    expect_log("fe_0", 0, 8'hFE, 4'd8, 1'b0);
    expect_log("fe_1", 1, 8'h80, 4'd1, 1'b1);

    do_reset();
    overflow_run();
    idle(1'b1, 6);
    chk("ovf_count", 32'(dut_log.size()), 4);
    expect_log("ovf_0", 0, 8'h11, 4'd8, 1'b0);
    expect_log("ovf_1", 1, 8'h22, 4'd8, 1'b0);
    expect_log("ovf_2", 2, 8'h33, 4'd8, 1'b0);
    expect_log("ovf_3", 3, 8'h44, 4'd8, 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, i == 3, 2'b10, 1'b1);
    idle(1'b1, 3);
    chk("aa_count", 32'(dut_log.size()), 1);
    expect_log("aa", 0, 8'hAA, 4'd8, 1'b1);

`ifdef SYMBOL_PACKER_STATS_EN
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++)
        cycle(1'b1, 1'b0, i == 3, 2'($urandom), 1'b1);
      idle(1'b1, 2);
    end
    overflow_run();
    chk("stat_frames", 32'(frame_cnt), 3);
    chk("stat_drops", 32'(drop_cnt), 1);
    idle(1'b1, 6);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, 2'($urandom),
              $urandom_range(0, 9) < 7);
      end
    end
    idle(1'b1, 8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
